// File: rtl/rf_scoreboard.sv
// Register file with combinational read ports, one write-back port and a per-register
// pending-write scoreboard. Define RF_BYPASS_EN to forward same-cycle write-back to reads.
module rf_scoreboard #(
  parameter int A_WIDTH  = 5,
  parameter int D_WIDTH  = 32,
  parameter int NR       = 2,
  parameter int CNT_W    = 2,
  parameter int TRIG_IDX = 9,
  parameter int DBG_IDX  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  input  logic [A_WIDTH-1:0]     iss_rd,
  output logic                   iss_ready,
  input  logic                   wb_we,
  input  logic [A_WIDTH-1:0]     wb_ad,
  input  logic [D_WIDTH-1:0]     wb_wd,
  input  logic                   trigger,
  input  logic [NR*A_WIDTH-1:0]  rd_ad,
  output logic [NR*D_WIDTH-1:0]  rd_data,
  output logic [NR-1:0]          rd_busy,
  output logic [D_WIDTH-1:0]     dbg_data
);

  localparam int DEPTH = 2**A_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [D_WIDTH-1:0] regs [DEPTH];
  logic [CNT_W-1:0]   cnt  [DEPTH];
  logic [DEPTH-1:0]   inc_vec;
  logic [DEPTH-1:0]   dec_vec;
  logic               iss_fire;
  logic [A_WIDTH-1:0] ad;

  // A full counter can still accept an issue when a write-back retires one in the same cycle.
  always_comb begin
    iss_ready = (iss_rd == '0) || (cnt[iss_rd] != CNT_MAX) || (wb_we && (wb_ad == iss_rd));
  end

  assign iss_fire = iss_valid && iss_ready && (iss_rd != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < DEPTH; r++) begin
      inc_vec[r] = iss_fire && (iss_rd == A_WIDTH'(r));
      dec_vec[r] = wb_we && (wb_ad == A_WIDTH'(r)) && (cnt[r] != '0);
    end
  end

  // Write-back is assigned last so it overrides a same-edge trigger preset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      if (trigger && (TRIG_IDX != 0)) regs[A_WIDTH'(TRIG_IDX)] <= D_WIDTH'(1);
      if (wb_we && (wb_ad != '0)) regs[wb_ad] <= wb_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (inc_vec[r] && !dec_vec[r])      cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ad      = '0;
    for (int i = 0; i < NR; i++) begin
      ad = rd_ad[i*A_WIDTH +: A_WIDTH];
      rd_data[i*D_WIDTH +: D_WIDTH] = regs[ad];
      rd_busy[i] = (ad != '0) && (cnt[ad] != '0);
`ifdef RF_BYPASS_EN
      // The forwarded write retires the last pending issue only when exactly one is in flight.
      if (!rst && wb_we && (wb_ad == ad) && (ad != '0)) begin
        rd_data[i*D_WIDTH +: D_WIDTH] = wb_wd;
        if (cnt[ad] == CNT_W'(1)) rd_busy[i] = 1'b0;
      end
`endif
    end
  end

  assign dbg_data = regs[A_WIDTH'(DBG_IDX)];

endmodule
